// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: FSM states, command bytes, power-up init list
// and the long-execution-time command test.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] code;
  } lcd_xfer_t;

  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_HOME       = 8'h02;
  localparam logic [7:0] LCD_ENTRY      = 8'h06;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] LCD_LINE2      = 8'hC0;

  localparam int unsigned INIT_LEN   = 5;
  localparam int unsigned INIT_IDX_W = 3;

  function automatic logic [7:0] init_byte(input logic [INIT_IDX_W-1:0] i);
    case (i)
      3'd0:    return LCD_FUNC_8B2L;
      3'd1:    return LCD_FUNC_8B2L;
      3'd2:    return LCD_DISP_ON;
      3'd3:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  // Clear and return-home (0x01..0x03 as commands) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return !rs && (code[7:2] == 6'd0) && (code != 8'd0);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// HD44780 byte writer: runs the power-up init sequence, then writes upstream
// bytes with setup / EN pulse / hold / execution-wait timing.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 750_000,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_CYC         = 25,
  parameter int unsigned HOLD_CYC       = 4,
  parameter int unsigned SHORT_WAIT_CYC = 2_500,
  parameter int unsigned LONG_WAIT_CYC  = 82_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       init_done,
  output logic       EN,
  output logic       RW,
  output logic       RS,
  output logic [7:0] data
);

  localparam int unsigned MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                                         max2(SHORT_WAIT_CYC, LONG_WAIT_CYC));
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  lcd_state_e              state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [INIT_IDX_W-1:0]   idx, idx_n;
  lcd_xfer_t               xfer, xfer_n;
  logic                    init_done_n;
  logic                    en_n;
  logic                    cnt_done;
  logic [CNT_W-1:0]        wait_load;

  assign cnt_done  = (cnt == '0);
  assign wait_load = is_long_cmd(xfer.rs, xfer.code) ? CNT_W'(LONG_WAIT_CYC - 1)
                                                     : CNT_W'(SHORT_WAIT_CYC - 1);

  // State register; EN is registered so it has no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      cnt       <= CNT_W'(POWERUP_CYC - 1);
      idx       <= '0;
      xfer      <= '0;
      init_done <= 1'b0;
      EN        <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      xfer      <= xfer_n;
      init_done <= init_done_n;
      EN        <= en_n;
    end
  end

  // Next-state logic; every phase reloads the single down-counter with N-1.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    xfer_n      = xfer;
    init_done_n = init_done;
    case (state)
      PWRUP: begin
        if (cnt_done) state_n = INIT_LOAD;
        else          cnt_n   = cnt - CNT_W'(1);
      end
      INIT_LOAD: begin
        xfer_n.rs   = 1'b0;
        xfer_n.code = init_byte(idx);
        idx_n       = idx + INIT_IDX_W'(1);
        state_n     = SETUP;
        cnt_n       = CNT_W'(SETUP_CYC - 1);
      end
      IDLE: begin
        if (in_valid) begin
          xfer_n.rs   = in_rs;
          xfer_n.code = in_byte;
          state_n     = SETUP;
          cnt_n       = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_n = PULSE;
          cnt_n   = CNT_W'(EN_CYC - 1);
        end else cnt_n = cnt - CNT_W'(1);
      end
      PULSE: begin
        if (cnt_done) begin
          state_n = HOLD;
          cnt_n   = CNT_W'(HOLD_CYC - 1);
        end else cnt_n = cnt - CNT_W'(1);
      end
      HOLD: begin
        if (cnt_done) begin
          state_n = WAIT;
          cnt_n   = wait_load;
        end else cnt_n = cnt - CNT_W'(1);
      end
      WAIT: begin
        if (cnt_done) begin
          if (init_done) begin
            state_n = IDLE;
          end else if (idx == INIT_IDX_W'(INIT_LEN)) begin
            state_n     = IDLE;
            init_done_n = 1'b1;
          end else begin
            state_n = INIT_LOAD;
          end
        end else cnt_n = cnt - CNT_W'(1);
      end
      default: begin
        state_n = PWRUP;
        cnt_n   = CNT_W'(POWERUP_CYC - 1);
      end
    endcase
  end

  // Outputs: ready is a pure state decode, EN follows the upcoming state.
  always_comb begin
    in_ready = (state == IDLE);
    en_n     = (state_n == PULSE);
  end

  assign RW   = 1'b0;
  assign RS   = xfer.rs;
  assign data = xfer.code;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Randomized bench for lcd_bus_writer with an arithmetic timing/scoreboard model.
module tb_lcd_bus_writer;

  localparam int unsigned P  = 10;
  localparam int unsigned S  = 2;
  localparam int unsigned E  = 3;
  localparam int unsigned H  = 2;
  localparam int unsigned SW = 5;
  localparam int unsigned LW = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       init_done;
  logic       EN;
  logic       RW;
  logic       RS;
  logic [7:0] data;

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .POWERUP_CYC(P), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rs(in_rs), .in_byte(in_byte),
    .in_ready(in_ready), .init_done(init_done), .EN(EN), .RW(RW), .RS(RS), .data(data)
  );

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] d;
  } ev_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   en_w = 0;
  int   rw_bad = 0;
  logic en_prev = 1'b0;
  ev_t  en_q[$];
  ev_t  acc_q[$];
  logic [7:0] init_list [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] b);
    return (!rs && b >= 8'd1 && b <= 8'd3) ? int'(LW) : int'(SW);
  endfunction

  function automatic int period(input logic rs, input logic [7:0] b);
    return int'(S + E + H) + wait_of(rs, b);
  endfunction

  // One clock: record acceptances and EN pulses, sample 1 time unit after the edge.
  task automatic tick();
    logic pre_acc, pre_rs;
    logic [7:0] pre_b;
    ev_t ev;
    pre_acc = in_valid && in_ready && rst_n;
    pre_rs  = in_rs;
    pre_b   = in_byte;
    @(posedge clk);
    #1;
    cyc++;
    if (RW !== 1'b0) rw_bad++;
    if (pre_acc) begin
      ev.cyc = cyc; ev.rs = pre_rs; ev.d = pre_b;
      acc_q.push_back(ev);
      check("acc_rs", RS, pre_rs);
      check("acc_data", data, pre_b);
    end
    if (EN && !en_prev) begin
      ev.cyc = cyc; ev.rs = RS; ev.d = data;
      en_q.push_back(ev);
      en_w = 0;
    end
    if (EN) en_w++;
    if (!EN && en_prev) check("en_width", en_w, E);
    en_prev = EN;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"}, EN, 0);
    check({tag, "_rw"}, RW, 0);
    check({tag, "_rs"}, RS, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_done"}, init_done, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    cyc     = 0;
    en_prev = 1'b0;
    en_w    = 0;
    en_q.delete();
    acc_q.delete();
  endtask

  // Compare the five init pulses against the rule-derived schedule.
  task automatic check_init(output int exp_done);
    int l;
    l = P;
    for (int i = 0; i < 5; i++) begin
      if (i < en_q.size()) begin
        check("init_en_cyc", en_q[i].cyc, l + 1 + int'(S));
        check("init_rs", en_q[i].rs, 0);
        check("init_data", en_q[i].d, init_list[i]);
      end else begin
        check("init_pulse_count", en_q.size(), 5);
      end
      l += 1 + int'(S + E + H) + wait_of(1'b0, init_list[i]);
    end
    exp_done = l;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!in_ready && n < budget) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send_one(input logic rs, input logic [7:0] b);
    int a, n0, last;
    n0 = acc_q.size();
    in_valid = 1'b1; in_rs = rs; in_byte = b;
    tick();
    in_valid = 1'b0; in_rs = 1'($urandom); in_byte = 8'($urandom);
    check("accept", acc_q.size(), n0 + 1);
    a = cyc;
    wait_ready(100);
    check("ready_gap", cyc - a, period(rs, b));
    check("hold_data", data, b);
    check("hold_rs", RS, rs);
    last = en_q.size() - 1;
    if (last >= 0) begin
      check("en_start", en_q[last].cyc, a + int'(S));
      check("en_data", en_q[last].d, b);
    end else begin
      check("en_seen", 0, 1);
    end
  endtask

  initial begin
    int done_cyc, exp_done, first_done, n;
    logic rs_l [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] b_l [5] = '{8'h41, 8'h01, 8'h14, 8'h00, 8'h02};
    logic rs_q [$];
    logic [7:0] b_q [$];
    logic rs_e [3];
    logic [7:0] b_e [3];
    logic r;
    logic [7:0] b;

    rst_n = 1'b0; in_valid = 1'b0; in_rs = 1'b0; in_byte = 8'h00;
    #3;
    check_reset_vals("reset");
    release_reset();

    done_cyc = -1;
    n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
    if (init_done) done_cyc = cyc;
    else check("init_timeout", 0, 1);
    check_init(exp_done);
    check("init_done_cyc", done_cyc, exp_done);
    check("ready_at_done", in_ready, 1);

    for (int i = 0; i < 5; i++) send_one(rs_l[i], b_l[i]);
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      send_one(r, b);
    end

    // Back-to-back with in_valid held high.
    for (int i = 0; i < 3; i++) begin
      rs_e[i] = 1'($urandom);
      b_e[i]  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rs_q.push_back(rs_e[i]);
      b_q.push_back(b_e[i]);
    end
    acc_q.delete();
    n = 0;
    while (rs_q.size() > 0 && n < 200) begin
      in_valid = 1'b1; in_rs = rs_q[0]; in_byte = b_q[0];
      tick();
      if (acc_q.size() > 3 - rs_q.size()) begin
        void'(rs_q.pop_front());
        void'(b_q.pop_front());
      end
      n++;
    end
    in_valid = 1'b0;
    check("b2b_count", acc_q.size(), 3);
    for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
      check("b2b_data", acc_q[i].d, b_e[i]);
      check("b2b_rs", acc_q[i].rs, rs_e[i]);
      if (i > 0) check("b2b_spacing", acc_q[i].cyc - acc_q[i-1].cyc, period(rs_e[i-1], b_e[i-1]) + 1);
    end
    wait_ready(100);

    // Reset in the middle of an EN pulse, with upstream already waiting.
    in_valid = 1'b1; in_rs = 1'b1; in_byte = 8'h48;
    tick();
    n = 0;
    while (!EN && n < 50) begin
      tick();
      n++;
    end
    check("pulse_reached", EN, 1);
    in_byte = 8'h5A;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    release_reset();

    first_done = -1;
    n = 0;
    while (acc_q.size() == 0 && n < 400) begin
      tick();
      if (init_done && first_done < 0) first_done = cyc;
      n++;
    end
    in_valid = 1'b0;
    check_init(exp_done);
    check("replay_done_cyc", first_done, exp_done);
    if (acc_q.size() > 0) begin
      check("first_acc_cyc", acc_q[0].cyc, exp_done + 1);
      check("first_acc_data", acc_q[0].d, 8'h5A);
    end else begin
      check("first_acc_seen", 0, 1);
    end
    wait_ready(100);
    check("rw_low", rw_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
